// File: rtl/sva_result_collector.sv
// sva_result_collector
//   Collects the per-evaluation pulses of an SVA-FSM checker (succ, fail,
//   lazy_succ) into gclk periods. The periods are delimited by tick, the
//   checker's gclk posedge flag. One record per non-empty period goes into a
//   small first-word-fall-through FIFO. The block also keeps saturating
//   totals, the index of the first failing period and a sticky verdict.
//
// Ports
//   sys_clk, sys_rst   clock; synchronous active-low reset
//   tick               closes the current period (its pulses belong to it)
//   succ/fail/lazy_succ checker pulses, any combination per cycle
//   clr                synchronous clear, same effect as reset
//   rec_valid/rec_ready FIFO head handshake; rec_period/succ/fail/lazy = head
//   tot_succ/fail/lazy saturating totals over closed periods
//   first_fail_valid/first_fail_period  first period with a fail
//   verdict            0 IDLE, 1 PENDING, 2 PASS, 3 FAIL
//   drop_cnt           saturating count of records lost to a full FIFO
//   overflow           sticky: drop or any counter saturation
module sva_result_collector #(
  parameter int CNT_WIDTH    = 8,
  parameter int TOT_WIDTH    = 16,
  parameter int PERIOD_WIDTH = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    tick,
  input  logic                    succ,
  input  logic                    fail,
  input  logic                    lazy_succ,
  input  logic                    clr,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [PERIOD_WIDTH-1:0] rec_period,
  output logic [CNT_WIDTH-1:0]    rec_succ,
  output logic [CNT_WIDTH-1:0]    rec_fail,
  output logic [CNT_WIDTH-1:0]    rec_lazy,
  output logic [TOT_WIDTH-1:0]    tot_succ,
  output logic [TOT_WIDTH-1:0]    tot_fail,
  output logic [TOT_WIDTH-1:0]    tot_lazy,
  output logic                    first_fail_valid,
  output logic [PERIOD_WIDTH-1:0] first_fail_period,
  output logic [1:0]              verdict,
  output logic [TOT_WIDTH-1:0]    drop_cnt,
  output logic                    overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    V_IDLE    = 2'd0,
    V_PENDING = 2'd1,
    V_PASS    = 2'd2,
    V_FAIL    = 2'd3
  } verdict_t;

  // Returns {saturated, value}: value+pulse, held at all-ones.
  function automatic logic [CNT_WIDTH:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] c,
                                                     input logic p);
    if (p && (c == {CNT_WIDTH{1'b1}})) return {1'b1, c};
    return {1'b0, c + {{(CNT_WIDTH-1){1'b0}}, p}};
  endfunction

  // Returns {saturated, value}: total+count, clamped to all-ones.
  function automatic logic [TOT_WIDTH:0] sat_add_tot(input logic [TOT_WIDTH-1:0] t,
                                                     input logic [CNT_WIDTH-1:0] c);
    logic [TOT_WIDTH:0] s;
    s = {1'b0, t} + (TOT_WIDTH+1)'(c);
    if (s[TOT_WIDTH]) return {1'b1, {TOT_WIDTH{1'b1}}};
    return s;
  endfunction

  logic [CNT_WIDTH-1:0]    p_succ, p_fail, p_lazy;
  logic [PERIOD_WIDTH-1:0] period_idx;
  logic [PTR_W:0]          wr_ptr, rd_ptr;
  logic [PERIOD_WIDTH-1:0] mem_period [FIFO_DEPTH];
  logic [CNT_WIDTH-1:0]    mem_succ   [FIFO_DEPTH];
  logic [CNT_WIDTH-1:0]    mem_fail   [FIFO_DEPTH];
  logic [CNT_WIDTH-1:0]    mem_lazy   [FIFO_DEPTH];
  verdict_t                state_q, state_d;

  logic [CNT_WIDTH:0]      inc_s, inc_f, inc_l;
  logic [TOT_WIDTH:0]      add_s, add_f, add_l;
  logic [CNT_WIDTH-1:0]    c_succ, c_fail, c_lazy;
  logic                    cnt_sat, tot_sat, has_rec, full, pop, push, drop;

  // Closing counts: running count plus this cycle's pulses
  always_comb begin
    inc_s   = sat_inc_cnt(p_succ, succ);
    inc_f   = sat_inc_cnt(p_fail, fail);
    inc_l   = sat_inc_cnt(p_lazy, lazy_succ);
    c_succ  = inc_s[CNT_WIDTH-1:0];
    c_fail  = inc_f[CNT_WIDTH-1:0];
    c_lazy  = inc_l[CNT_WIDTH-1:0];
    cnt_sat = inc_s[CNT_WIDTH] | inc_f[CNT_WIDTH] | inc_l[CNT_WIDTH];
    add_s   = sat_add_tot(tot_succ, c_succ);
    add_f   = sat_add_tot(tot_fail, c_fail);
    add_l   = sat_add_tot(tot_lazy, c_lazy);
    tot_sat = add_s[TOT_WIDTH] | add_f[TOT_WIDTH] | add_l[TOT_WIDTH];
    has_rec = (c_succ != '0) || (c_fail != '0) || (c_lazy != '0);
  end

  // FIFO control; extra pointer bit separates full from empty. A pop in the
  // same cycle frees the slot a push into a full FIFO lands in.
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign rec_valid = (wr_ptr != rd_ptr);
  assign pop       = rec_valid && rec_ready;
  assign push      = tick && has_rec && (!full || pop);
  assign drop      = tick && has_rec && full && !pop;

  assign rec_period = mem_period[rd_ptr[PTR_W-1:0]];
  assign rec_succ   = mem_succ[rd_ptr[PTR_W-1:0]];
  assign rec_fail   = mem_fail[rd_ptr[PTR_W-1:0]];
  assign rec_lazy   = mem_lazy[rd_ptr[PTR_W-1:0]];

  // Accumulation, totals and FIFO storage
  always_ff @(posedge sys_clk) begin
    if (!sys_rst || clr) begin
      p_succ            <= '0;
      p_fail            <= '0;
      p_lazy            <= '0;
      period_idx        <= '0;
      tot_succ          <= '0;
      tot_fail          <= '0;
      tot_lazy          <= '0;
      first_fail_valid  <= 1'b0;
      first_fail_period <= '0;
      drop_cnt          <= '0;
      overflow          <= 1'b0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_period[i] <= '0;
        mem_succ[i]   <= '0;
        mem_fail[i]   <= '0;
        mem_lazy[i]   <= '0;
      end
    end else begin
      if (tick) begin
        p_succ     <= '0;
        p_fail     <= '0;
        p_lazy     <= '0;
        period_idx <= period_idx + 1'b1;
        tot_succ   <= add_s[TOT_WIDTH-1:0];
        tot_fail   <= add_f[TOT_WIDTH-1:0];
        tot_lazy   <= add_l[TOT_WIDTH-1:0];
        if ((c_fail != '0) && !first_fail_valid) begin
          first_fail_valid  <= 1'b1;
          first_fail_period <= period_idx;
        end
      end else begin
        p_succ <= c_succ;
        p_fail <= c_fail;
        p_lazy <= c_lazy;
      end
      if (push) begin
        mem_period[wr_ptr[PTR_W-1:0]] <= period_idx;
        mem_succ[wr_ptr[PTR_W-1:0]]   <= c_succ;
        mem_fail[wr_ptr[PTR_W-1:0]]   <= c_fail;
        mem_lazy[wr_ptr[PTR_W-1:0]]   <= c_lazy;
        wr_ptr                        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop && (drop_cnt != {TOT_WIDTH{1'b1}})) drop_cnt <= drop_cnt + 1'b1;
      if (drop || cnt_sat || (tick && tot_sat)) overflow <= 1'b1;
    end
  end

  // Verdict FSM, advanced only at tick; a fail in the period always wins
  always_ff @(posedge sys_clk) begin
    if (!sys_rst || clr) state_q <= V_IDLE;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      if (c_fail != '0) begin
        state_d = V_FAIL;
      end else begin
        case (state_q)
          V_IDLE, V_PENDING: state_d = (add_s[TOT_WIDTH-1:0] != '0) ? V_PASS : V_PENDING;
          default:           state_d = state_q;
        endcase
      end
    end
  end

  assign verdict = state_q;

endmodule

// File: tb/tb_sva_result_collector.sv
// Directed bench for sva_result_collector (default parameters).
module tb_sva_result_collector;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        tick = 1'b0, succ = 1'b0, fail = 1'b0, lazy_succ = 1'b0, clr = 1'b0;
  logic        rec_valid, rec_ready = 1'b0;
  logic [15:0] rec_period;
  logic [7:0]  rec_succ, rec_fail, rec_lazy;
  logic [15:0] tot_succ, tot_fail, tot_lazy;
  logic        first_fail_valid;
  logic [15:0] first_fail_period;
  logic [1:0]  verdict;
  logic [15:0] drop_cnt;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  sva_result_collector dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tick(tick), .succ(succ), .fail(fail),
    .lazy_succ(lazy_succ), .clr(clr), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_period(rec_period), .rec_succ(rec_succ), .rec_fail(rec_fail), .rec_lazy(rec_lazy),
    .tot_succ(tot_succ), .tot_fail(tot_fail), .tot_lazy(tot_lazy),
    .first_fail_valid(first_fail_valid), .first_fail_period(first_fail_period),
    .verdict(verdict), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  always #5 sys_clk = ~sys_clk;

  // One clock edge; inputs change and outputs are sampled 1 time unit later.
  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic f, input logic l, input logic t);
    succ = s; fail = f; lazy_succ = l; tick = t;
    cyc();
    succ = 1'b0; fail = 1'b0; lazy_succ = 1'b0; tick = 1'b0;
  endtask

  task automatic apply_reset();
    sys_rst = 1'b0;
    repeat (3) cyc();
    sys_rst = 1'b1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b0;
    repeat (3) cyc();
    checks++; if (rec_valid !== 1'b0) begin failures++; $display("FAIL reset_rec_valid got=%0d exp=0", rec_valid); end
    checks++; if (verdict !== 2'd0) begin failures++; $display("FAIL reset_verdict got=%0d exp=0", verdict); end
    checks++; if (tot_succ !== 16'd0 || tot_fail !== 16'd0 || tot_lazy !== 16'd0) begin failures++; $display("FAIL reset_totals got=%0d/%0d/%0d exp=0/0/0", tot_succ, tot_fail, tot_lazy); end
    checks++; if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin failures++; $display("FAIL reset_drop_ovf got=%0d/%0d exp=0/0", drop_cnt, overflow); end
    checks++; if (first_fail_valid !== 1'b0 || first_fail_period !== 16'd0) begin failures++; $display("FAIL reset_first_fail got=%0d/%0d exp=0/0", first_fail_valid, first_fail_period); end
    sys_rst = 1'b1;
    repeat (5) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (rec_valid !== 1'b0) begin failures++; $display("FAIL idle_rec_valid got=%0d exp=0", rec_valid); end
    checks++; if (verdict !== 2'd1) begin failures++; $display("FAIL idle_verdict got=%0d exp=1", verdict); end
    checks++; if (tot_succ !== 16'd0 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin failures++; $display("FAIL idle_counters got=%0d/%0d/%0d exp=0/0/0", tot_succ, drop_cnt, overflow); end
  endtask

  task automatic test_simple_pass();
    apply_reset();
    rec_ready = 1'b1;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (rec_valid !== 1'b1) begin failures++; $display("FAIL pass_rec_valid got=%0d exp=1", rec_valid); end
    checks++; if (rec_period !== 16'd0 || rec_succ !== 8'd2 || rec_fail !== 8'd0 || rec_lazy !== 8'd0) begin failures++; $display("FAIL pass_record got=%0d/%0d/%0d/%0d exp=0/2/0/0", rec_period, rec_succ, rec_fail, rec_lazy); end
    checks++; if (tot_succ !== 16'd2) begin failures++; $display("FAIL pass_tot_succ got=%0d exp=2", tot_succ); end
    checks++; if (verdict !== 2'd2) begin failures++; $display("FAIL pass_verdict got=%0d exp=2", verdict); end
    cyc();
    checks++; if (rec_valid !== 1'b0) begin failures++; $display("FAIL pass_popped got=%0d exp=0", rec_valid); end
  endtask

  task automatic test_fail_priority();
    apply_reset();
    rec_ready = 1'b1;
    repeat (3) pulse(1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (verdict !== 2'd1) begin failures++; $display("FAIL lazy_verdict got=%0d exp=1", verdict); end
    checks++; if (rec_period !== 16'd2 || rec_lazy !== 8'd1) begin failures++; $display("FAIL lazy_record got=%0d/%0d exp=2/1", rec_period, rec_lazy); end
    pulse(1'b1, 1'b1, 1'b0, 1'b1);
    checks++; if (rec_valid !== 1'b1 || rec_period !== 16'd3 || rec_succ !== 8'd1 || rec_fail !== 8'd1 || rec_lazy !== 8'd0) begin failures++; $display("FAIL fail_record got=%0d:%0d/%0d/%0d/%0d exp=1:3/1/1/0", rec_valid, rec_period, rec_succ, rec_fail, rec_lazy); end
    checks++; if (first_fail_valid !== 1'b1 || first_fail_period !== 16'd3) begin failures++; $display("FAIL first_fail got=%0d/%0d exp=1/3", first_fail_valid, first_fail_period); end
    checks++; if (verdict !== 2'd3) begin failures++; $display("FAIL fail_verdict got=%0d exp=3", verdict); end
    checks++; if (tot_lazy !== 16'd3 || tot_fail !== 16'd1) begin failures++; $display("FAIL fail_totals got=%0d/%0d exp=3/1", tot_lazy, tot_fail); end
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (verdict !== 2'd3) begin failures++; $display("FAIL sticky_verdict got=%0d exp=3", verdict); end
    checks++; if (first_fail_period !== 16'd3 || rec_period !== 16'd4 || tot_succ !== 16'd2) begin failures++; $display("FAIL sticky_state got=%0d/%0d/%0d exp=3/4/2", first_fail_period, rec_period, tot_succ); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    rec_ready = 1'b0;
    repeat (6) pulse(1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (rec_valid !== 1'b1 || rec_period !== 16'd0) begin failures++; $display("FAIL bp_head got=%0d/%0d exp=1/0", rec_valid, rec_period); end
    checks++; if (drop_cnt !== 16'd2) begin failures++; $display("FAIL bp_drop_cnt got=%0d exp=2", drop_cnt); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow got=%0d exp=1", overflow); end
    checks++; if (tot_succ !== 16'd6) begin failures++; $display("FAIL bp_tot_succ got=%0d exp=6", tot_succ); end
    cyc();
    checks++; if (rec_period !== 16'd0) begin failures++; $display("FAIL bp_hold got=%0d exp=0", rec_period); end
    rec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rec_valid !== 1'b1 || rec_period !== 16'(i) || rec_succ !== 8'd1) begin failures++; $display("FAIL bp_read got=%0d:%0d/%0d exp=1:%0d/1", rec_valid, rec_period, rec_succ, i); end
      cyc();
    end
    checks++; if (rec_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%0d exp=0", rec_valid); end
  endtask

  task automatic test_full_pop();
    apply_reset();
    rec_ready = 1'b0;
    repeat (4) pulse(1'b1, 1'b0, 1'b0, 1'b1);
    rec_ready = 1'b1;
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin failures++; $display("FAIL fp_no_drop got=%0d/%0d exp=0/0", drop_cnt, overflow); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (rec_valid !== 1'b1 || rec_period !== 16'(i) || rec_succ !== 8'd1) begin failures++; $display("FAIL fp_read got=%0d:%0d/%0d exp=1:%0d/1", rec_valid, rec_period, rec_succ, i); end
      cyc();
    end
    checks++; if (rec_valid !== 1'b1 || rec_period !== 16'd4 || rec_succ !== 8'd0 || rec_lazy !== 8'd1) begin failures++; $display("FAIL fp_last got=%0d:%0d/%0d/%0d exp=1:4/0/1", rec_valid, rec_period, rec_succ, rec_lazy); end
    cyc();
    checks++; if (rec_valid !== 1'b0) begin failures++; $display("FAIL fp_empty got=%0d exp=0", rec_valid); end
  endtask

  task automatic test_saturation_clr();
    apply_reset();
    rec_ready = 1'b0;
    succ = 1'b1;
    repeat (300) cyc();
    succ = 1'b0;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (rec_valid !== 1'b1 || rec_period !== 16'd0 || rec_succ !== 8'd255) begin failures++; $display("FAIL sat_record got=%0d:%0d/%0d exp=1:0/255", rec_valid, rec_period, rec_succ); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL sat_overflow got=%0d exp=1", overflow); end
    checks++; if (tot_succ !== 16'd255 || verdict !== 2'd2) begin failures++; $display("FAIL sat_tot_verdict got=%0d/%0d exp=255/2", tot_succ, verdict); end
    clr = 1'b1;
    pulse(1'b1, 1'b1, 1'b0, 1'b1);
    clr = 1'b0;
    checks++; if (rec_valid !== 1'b0) begin failures++; $display("FAIL clr_rec_valid got=%0d exp=0", rec_valid); end
    checks++; if (verdict !== 2'd0 || first_fail_valid !== 1'b0) begin failures++; $display("FAIL clr_verdict got=%0d/%0d exp=0/0", verdict, first_fail_valid); end
    checks++; if (tot_succ !== 16'd0 || tot_fail !== 16'd0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin failures++; $display("FAIL clr_counters got=%0d/%0d/%0d/%0d exp=0/0/0/0", tot_succ, tot_fail, overflow, drop_cnt); end
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (rec_valid !== 1'b1 || rec_period !== 16'd0 || rec_succ !== 8'd1) begin failures++; $display("FAIL clr_period_idx got=%0d:%0d/%0d exp=1:0/1", rec_valid, rec_period, rec_succ); end
  endtask

  initial begin
    test_reset();
    test_simple_pass();
    test_fail_priority();
    test_backpressure();
    test_full_pop();
    test_saturation_clr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
